oob_device_control: RTL

OOB_DEVICE_CONTROL -- requirements
Module: oob_device_control

---
 rtl/sata_prim_pkg.sv | 30 +++
 rtl/sata_prim_det.sv | 21 ++
 rtl/oob_device_control.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sata_prim_pkg.sv
// Shared SATA primitive constants, OOB device FSM state encodings and TX source select.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sata_prim_pkg;

  localparam logic [31:0] ALIGN_PRIM = 32'h7B4A4ABC;  // K28.5 D10.2 D10.2 D27.3
  localparam logic [31:0] SYNC_PRIM  = 32'hB5B5957C;  // K28.3 D21.4 D21.5 D21.5
  localparam logic [31:0] DIAL_PRIM  = 32'h4A4A4A4A;  // D10.2 dial tone

  localparam int CNT_W = 18;

  typedef enum logic [2:0] {
    DEV_IDLE          = 3'd0,
    DEV_COMINIT       = 3'd1,
    WAIT_HOST_COMWAKE = 3'd2,
    DEV_COMWAKE       = 3'd3,
    WAIT_COMWAKE_END  = 3'd4,
    DEV_SEND_ALIGN    = 3'd5,
    DEV_SEND_SYNC     = 3'd6,
    LINK_READY        = 3'd7
  } dev_state_e;

  // Registered choice of what drives the TX dword.
  typedef enum logic [1:0] {
    TX_SEL_ALIGN = 2'd0,
    TX_SEL_SYNC  = 2'd1,
    TX_SEL_DATA  = 2'd2
  } tx_sel_e;

endpackage

// File: rtl/sata_prim_det.sv
// Recognises ALIGN, SYNC and D10.2 dial tone on a received dword.
// Latency: combinational, 0 cycles.
// Backpressure: none; evaluates every cycle.
// Ports: rx_dat (registered RX dword), rxbyteisaligned (registered comma-aligned flag),
//        align_det / sync_det / dial_det (primitive match flags).
module sata_prim_det
  import sata_prim_pkg::*;
(
  input  logic [31:0] rx_dat,
  input  logic        rxbyteisaligned,
  output logic        align_det,
  output logic        sync_det,
  output logic        dial_det
);

  // An ALIGN only counts once the comma aligner has locked byte boundaries.
  assign align_det = (rx_dat == ALIGN_PRIM) && rxbyteisaligned;
  assign sync_det  = (rx_dat == SYNC_PRIM);
  assign dial_det  = (rx_dat == DIAL_PRIM);

endmodule

// File: rtl/oob_device_control.sv
// SATA device-side OOB sequencer: COMRESET/COMINIT/COMWAKE handshake, ALIGN/SYNC bring-up, link pass-through.
// Latency: RX inputs registered once (1 cycle); TX source select registered (1 cycle), tx_datain path combinational.
// Backpressure: none; align_en_out asks the link layer to pause for 2 of every 256 dwords.
// Ports: clk/reset (sync active-high); GTX status rx_locked, gen2, comresetdet, comwakedet, rxelecidle,
//        rxbyteisaligned; RX dword rx_datain/rx_charisk_in in, rx_dataout/rx_charisk_out out;
//        TX dword tx_datain/tx_charisk_in in, tx_dataout/tx_charisk_out out; OOB controls txcominit,
//        txcomwake, txelecidle_out; status linkup, align_en_out, CurrentState_out.
module oob_device_control
  import sata_prim_pkg::*;
#(
  parameter int COMINIT_G1 = 81,
  parameter int COMINIT_G2 = 162,
  parameter int COMWAKE_G1 = 78,
  parameter int COMWAKE_G2 = 155,
  parameter int TIMEOUT    = 132013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_locked,
  input  logic        gen2,
  input  logic        comresetdet,
  input  logic        comwakedet,
  input  logic        rxelecidle,
  input  logic        rxbyteisaligned,
  input  logic [31:0] rx_datain,
  input  logic [3:0]  rx_charisk_in,
  input  logic [31:0] tx_datain,
  input  logic        tx_charisk_in,
  output logic        txcominit,
  output logic        txcomwake,
  output logic        txelecidle_out,
  output logic [31:0] tx_dataout,
  output logic        tx_charisk_out,
  output logic [31:0] rx_dataout,
  output logic [3:0]  rx_charisk_out,
  output logic        linkup,
  output logic        align_en_out,
  output logic [7:0]  CurrentState_out
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  // Single registered copy of every RX-side input; all decisions use these.
  logic [31:0] rx_datain_r;
  logic [3:0]  rx_charisk_in_r;
  logic        rxelecidle_r;
  logic        rxbyteisaligned_r;
  logic        comresetdet_r;
  logic        comwakedet_r;

  dev_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       align_cnt_q, align_cnt_d;
  tx_sel_e          tx_sel_q, tx_sel_d;

  logic             align_det, sync_det, dial_det;
  logic [CNT_W-1:0] cominit_len, comwake_len;
  logic             link_live;

  sata_prim_det u_prim_det (
    .rx_dat          (rx_datain_r),
    .rxbyteisaligned (rxbyteisaligned_r),
    .align_det       (align_det),
    .sync_det        (sync_det),
    .dial_det        (dial_det)
  );

  assign cominit_len = gen2 ? CNT_W'(COMINIT_G2) : CNT_W'(COMINIT_G1);
  assign comwake_len = gen2 ? CNT_W'(COMWAKE_G2) : CNT_W'(COMWAKE_G1);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_datain_r       <= '0;
      rx_charisk_in_r   <= '0;
      rxelecidle_r      <= 1'b0;
      rxbyteisaligned_r <= 1'b0;
      comresetdet_r     <= 1'b0;
      comwakedet_r      <= 1'b0;
      state_q           <= DEV_IDLE;
      cnt_q             <= '0;
      align_cnt_q       <= '0;
      tx_sel_q          <= TX_SEL_ALIGN;
    end else begin
      rx_datain_r       <= rx_datain;
      rx_charisk_in_r   <= rx_charisk_in;
      rxelecidle_r      <= rxelecidle;
      rxbyteisaligned_r <= rxbyteisaligned;
      comresetdet_r     <= comresetdet;
      comwakedet_r      <= comwakedet;
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      align_cnt_q       <= align_cnt_d;
      tx_sel_q          <= tx_sel_d;
    end
  end

  // Next state and wait counter. The counter only advances while the current
  // state is still waiting, and restarts from zero on any state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DEV_IDLE: begin
        if (comresetdet_r && rx_locked) state_d = DEV_COMINIT;
      end
      DEV_COMINIT: begin
        if (cnt_q == cominit_len) state_d = WAIT_HOST_COMWAKE;
        else                      cnt_d   = cnt_q + 1'b1;
      end
      WAIT_HOST_COMWAKE: begin
        // Detect is checked first so it beats a same-cycle timeout.
        if (comwakedet_r)              state_d = DEV_COMWAKE;
        else if (cnt_q == TIMEOUT_CNT) state_d = DEV_IDLE;
        else                           cnt_d   = cnt_q + 1'b1;
      end
      DEV_COMWAKE: begin
        if (cnt_q == comwake_len) state_d = WAIT_COMWAKE_END;
        else                      cnt_d   = cnt_q + 1'b1;
      end
      WAIT_COMWAKE_END: begin
        if (!rxelecidle_r) state_d = DEV_SEND_ALIGN;
      end
      DEV_SEND_ALIGN: begin
        if (align_det)                 state_d = DEV_SEND_SYNC;
        else if (cnt_q == TIMEOUT_CNT) state_d = DEV_IDLE;
        else                           cnt_d   = cnt_q + 1'b1;
      end
      DEV_SEND_SYNC: begin
        // Leave on the first real dword from the host: a SYNC or any payload
        // that is neither ALIGN nor dial tone.
        if (!align_det && (sync_det || !dial_det)) state_d = LINK_READY;
      end
      LINK_READY: begin
        state_d = LINK_READY;
      end
      default: state_d = DEV_IDLE;
    endcase

    // A host COMRESET once the handshake is under way restarts it.
    if (comresetdet_r && (state_q != DEV_IDLE) && (state_q != DEV_COMINIT))
      state_d = DEV_COMINIT;

    if (state_d != state_q) cnt_d = '0;
  end

  // TX source chosen from the current state, applied one cycle later.
  always_comb begin
    tx_sel_d = TX_SEL_ALIGN;
    case (state_q)
      DEV_SEND_SYNC: tx_sel_d = TX_SEL_SYNC;
      LINK_READY:    tx_sel_d = TX_SEL_DATA;
      default:       tx_sel_d = TX_SEL_ALIGN;
    endcase
  end

  // Free-running ALIGN slot counter, wraps 255 -> 0.
  assign align_cnt_d  = align_cnt_q + 8'd1;
  assign align_en_out = (align_cnt_q <= 8'd1);

  always_comb begin
    tx_dataout     = ALIGN_PRIM;
    tx_charisk_out = 1'b1;
    case (tx_sel_q)
      TX_SEL_SYNC: begin
        tx_dataout     = SYNC_PRIM;
        tx_charisk_out = 1'b1;
      end
      TX_SEL_DATA: begin
        if (!align_en_out) begin
          tx_dataout     = tx_datain;
          tx_charisk_out = tx_charisk_in;
        end
      end
      default: begin
        tx_dataout     = ALIGN_PRIM;
        tx_charisk_out = 1'b1;
      end
    endcase
  end

  assign txcominit      = (state_q == DEV_COMINIT) && (cnt_q != cominit_len);
  assign txcomwake      = (state_q == DEV_COMWAKE) && (cnt_q != comwake_len);
  assign txelecidle_out = (state_q <= WAIT_COMWAKE_END);

  // RX is only forwarded while the link is up and the line is active.
  assign link_live      = (state_q == LINK_READY) && !rxelecidle_r;
  // A pending COMRESET drops linkup in the cycle before the FSM leaves LINK_READY.
  assign linkup         = link_live && !comresetdet_r;
  assign rx_dataout     = link_live ? rx_datain_r : 32'd0;
  assign rx_charisk_out = link_live ? rx_charisk_in_r : 4'd0;

  assign CurrentState_out = {5'd0, state_q};

endmodule
